prng_mux_gen: RTL and testbench
===============================

Name: prng_mux_gen

Overview:
- Parametrised pseudo-random number generator: a 2N-bit data LFSR feeds N 2:1 selectors, and an N-bit control LFSR drives the selects.
- Replaces derived-clock generation with a single-clock tick-enable divider.
- Adds an on-demand request mode with a VALID/BUSY handshake, runtime seed loading and lock-up protection.
- Sits between the board clock and the display/decoder logic (7-segment decoders consume OUT).

Parameters:
- N, 8, output width; data LFSR is 2N bits, control LFSR is N bits.
- DATA_TAPS, 16'hD008, 2N-bit XNOR tap mask for the data LFSR.
- CTRL_TAPS, 8'hB8, N-bit XNOR tap mask for the control LFSR.
- DATA_SEED, 0, data LFSR reset value; must not be all-ones.
- CTRL_SEED, 0, control LFSR reset value; must not be all-ones.
- TICK_DIV, 50000000, CLK cycles per free-run sample (≥2).
- CTRL_STEP, 1, control LFSR advances once per CTRL_STEP data steps (≥1).
- ROUNDS, 1, data steps performed per on-demand request (≥1).

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- RST  in  1  synchronous reset, active-high.
- EN  in  1  run enable; low freezes the counters, LFSRs and FSM.
- MODE  in  1  0 = free-run on tick, 1 = on-demand via REQ.
- REQ  in  1  sample request, sampled when MODE=1, EN=1 and BUSY=0.
- SEED_LD  in  1  load SEED_DATA/SEED_CTRL this cycle.
- SEED_DATA  in  2N  data LFSR seed.
- SEED_CTRL  in  N  control LFSR seed.
- OUT  out  N  registered random value.
- VALID  out  1  one-cycle pulse when OUT updates.
- BUSY  out  1  on-demand generation in progress.
- TICK_TGL  out  1  toggles on every free-run sample (indicator).

Behaviour:
- Reset (RST=1 at an edge) sets:
  - data LFSR=DATA_SEED, control LFSR=CTRL_SEED;
  - tick counter=0, step counter=0;
  - OUT=0, VALID=0, BUSY=0, TICK_TGL=0;
  - FSM=IDLE.
  RST has priority over all other inputs.
- LFSR step: shift left, insert feedback at bit0.
  - Data LFSR feedback = XNOR-reduce(data & DATA_TAPS).
  - Control LFSR feedback = XNOR-reduce(ctrl & CTRL_TAPS).
- Control LFSR cadence: the step counter counts data steps modulo CTRL_STEP; the control LFSR steps on the data step where the counter wraps to 0. With CTRL_STEP=1 it steps on every data step.
- Mux: OUT_next[j] = ctrl[j] ? data[2j+1] : data[2j], computed from the post-step LFSR values.
- Latency: OUT and VALID register on the edge after the final step edge. VALID is high for exactly one cycle.
- Free-run (MODE=0, EN=1):
  - The tick counter counts 0..TICK_DIV-1.
  - At count TICK_DIV-1: one data step, counter→0, TICK_TGL toggles.
  - REQ is ignored.
- On-demand FSM (states IDLE, GEN, DONE):
  - IDLE: if MODE=1 and REQ=1, go to GEN, BUSY=1, round count=0.
  - GEN: one data step per cycle. After ROUNDS steps, go to DONE.
  - DONE: OUT updated, VALID=1, BUSY=0, go to IDLE.
  - REQ during BUSY is ignored (no queueing).
  - A MODE change during BUSY does not abort; the request completes.
  - The tick counter is held at 0 while MODE=1.
- EN=0:
  - All state holds, including mid-GEN and the tick count.
  - VALID is forced 0.
  - Operation resumes exactly where it stopped when EN returns to 1.
- SEED_LD=1 (priority just below RST, effective regardless of EN):
  - Loads both LFSRs; any all-ones seed is replaced by all-zeros (XNOR lock-up guard).
  - Clears the tick counter and step counter.
  - Aborts GEN: FSM→IDLE, BUSY=0, no VALID.
  - OUT holds its value.
- Simultaneous SEED_LD and tick/REQ: the seed load wins; no step occurs that cycle and the REQ is dropped.
- Free-run tick counter wrap: exactly TICK_DIV cycles between consecutive VALIDs while EN=1.

Test Plan:
- Reset/free-run (N=8, TICK_DIV=4, default taps/seeds, EN=1, MODE=0): release RST → first step at the 4th edge gives data=0x0001, ctrl=0x01; OUT=0x00 with VALID=1 after the 5th edge. Second VALID 4 cycles later: OUT=0x01, data=0x0003, ctrl=0x03. TICK_TGL toggles at edges 4 and 8.
- On-demand (MODE=1, ROUNDS=2): 1-cycle REQ pulse from reset state → BUSY high for 2 cycles, then VALID with OUT=0x01. A REQ during BUSY produces no second VALID.
- EN freeze: drop EN for 10 cycles mid-GEN → BUSY stays 1, LFSRs unchanged, VALID=0. Restore EN → VALID arrives after the remaining rounds.
- Seed guard: SEED_LD with SEED_DATA=0xFFFF, SEED_CTRL=0xFF → both LFSRs read 0. The next free-run sample equals the post-reset sequence (OUT=0x00, then 0x01).
- SEED_LD during GEN plus a simultaneous REQ → BUSY clears next cycle, no VALID, OUT unchanged.
- Long run (N=8, default taps): over 65535 data steps the data LFSR never reaches 0xFFFF; OUT is never X; the VALID count equals the tick count.

Source files
------------

// File: rtl/prng_mux_gen.sv
// Pseudo-random generator: a 2N-bit data LFSR feeds N 2:1 selectors steered by an N-bit control LFSR.
// Samples are taken either free-running on a divided tick, or on demand through a REQ/BUSY/VALID handshake.
module prng_mux_gen #(
  parameter int unsigned    N         = 8,
  parameter logic [2*N-1:0] DATA_TAPS = 16'hD008,
  parameter logic [N-1:0]   CTRL_TAPS = 8'hB8,
  parameter logic [2*N-1:0] DATA_SEED = '0,
  parameter logic [N-1:0]   CTRL_SEED = '0,
  parameter int unsigned    TICK_DIV  = 50000000,
  parameter int unsigned    CTRL_STEP = 1,
  parameter int unsigned    ROUNDS    = 1
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           EN,
  input  logic           MODE,
  input  logic           REQ,
  input  logic           SEED_LD,
  input  logic [2*N-1:0] SEED_DATA,
  input  logic [N-1:0]   SEED_CTRL,
  output logic [N-1:0]   OUT,
  output logic           VALID,
  output logic           BUSY,
  output logic           TICK_TGL
);

  localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned SW = (CTRL_STEP > 1) ? $clog2(CTRL_STEP) : 1;
  localparam int unsigned RW = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;

  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SCNT_LAST = SW'(CTRL_STEP - 1);
  localparam logic [RW-1:0] RND_LAST  = RW'(ROUNDS - 1);

  typedef enum logic [1:0] {StIdle, StGen, StDone} state_e;

  state_e         state_q;
  logic [2*N-1:0] data_q;
  logic [N-1:0]   ctrl_q;
  logic [SW-1:0]  scnt_q;
  logic [TW-1:0]  tick_q;
  logic [RW-1:0]  round_q;
  logic [N-1:0]   out_q;
  logic           valid_q;
  logic           busy_q;
  logic           tgl_q;

  logic [2*N-1:0] data_step;
  logic [N-1:0]   ctrl_step;
  logic [SW-1:0]  scnt_step;
  logic [N-1:0]   out_mux;
  logic [2*N-1:0] seed_data_g;
  logic [N-1:0]   seed_ctrl_g;

  always_comb begin
    data_step = {data_q[2*N-2:0], ~^(data_q & DATA_TAPS)};
    ctrl_step = ctrl_q;
    scnt_step = scnt_q + SW'(1);
    if (scnt_q == SCNT_LAST) begin
      scnt_step = '0;
      ctrl_step = {ctrl_q[N-2:0], ~^(ctrl_q & CTRL_TAPS)};
    end
    out_mux = '0;
    for (int j = 0; j < N; j++) begin
      out_mux[j] = ctrl_q[j] ? data_q[2*j+1] : data_q[2*j];
    end
    // All-ones is the XNOR lock-up state, so it is never loaded.
    seed_data_g = (SEED_DATA == '1) ? '0 : SEED_DATA;
    seed_ctrl_g = (SEED_CTRL == '1) ? '0 : SEED_CTRL;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StIdle;
      data_q  <= DATA_SEED;
      ctrl_q  <= CTRL_SEED;
      scnt_q  <= '0;
      tick_q  <= '0;
      round_q <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      tgl_q   <= 1'b0;
    end else if (SEED_LD) begin
      state_q <= StIdle;
      data_q  <= seed_data_g;
      ctrl_q  <= seed_ctrl_g;
      scnt_q  <= '0;
      tick_q  <= '0;
      round_q <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else if (EN) begin
      valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (MODE) begin
            tick_q <= '0;
            if (REQ) begin
              state_q <= StGen;
              busy_q  <= 1'b1;
              round_q <= '0;
            end
          end else if (tick_q == TICK_LAST) begin
            tick_q  <= '0;
            tgl_q   <= ~tgl_q;
            data_q  <= data_step;
            ctrl_q  <= ctrl_step;
            scnt_q  <= scnt_step;
            state_q <= StDone;
          end else begin
            tick_q <= tick_q + TW'(1);
          end
        end
        StGen: begin
          data_q <= data_step;
          ctrl_q <= ctrl_step;
          scnt_q <= scnt_step;
          tick_q <= '0;
          if (round_q == RND_LAST) begin
            state_q <= StDone;
            busy_q  <= 1'b0;
          end else begin
            round_q <= round_q + RW'(1);
          end
        end
        StDone: begin
          // The LFSRs already hold the post-step values here.
          out_q   <= out_mux;
          valid_q <= 1'b1;
          state_q <= StIdle;
          tick_q  <= MODE ? '0 : tick_q + TW'(1);
        end
        default: state_q <= StIdle;
      endcase
    end else begin
      valid_q <= 1'b0;
    end
  end

  assign OUT      = out_q;
  assign VALID    = valid_q;
  assign BUSY     = busy_q;
  assign TICK_TGL = tgl_q;

endmodule

// File: tb/tb_prng_mux_gen.sv
// Self-checking bench for prng_mux_gen: a directed vector table, hand-written corner sequences, and
// randomized free-run/on-demand runs checked against a step-level LFSR reference model.
module tb_prng_mux_gen;

  localparam int TDIV  = 4;
  localparam int RND   = 2;
  localparam int CSTEP = 1;
  localparam logic [15:0] DTAPS = 16'hD008;
  localparam logic [7:0]  CTAPS = 8'hB8;

  logic        CLK = 1'b0;
  logic        RST, EN, MODE, REQ, SEED_LD;
  logic [15:0] SEED_DATA;
  logic [7:0]  SEED_CTRL;
  logic [7:0]  OUT;
  logic        VALID, BUSY, TICK_TGL;

  int errors = 0;
  int checks = 0;

  prng_mux_gen #(
    .N        (8),
    .TICK_DIV (TDIV),
    .CTRL_STEP(CSTEP),
    .ROUNDS   (RND)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .EN       (EN),
    .MODE     (MODE),
    .REQ      (REQ),
    .SEED_LD  (SEED_LD),
    .SEED_DATA(SEED_DATA),
    .SEED_CTRL(SEED_CTRL),
    .OUT      (OUT),
    .VALID    (VALID),
    .BUSY     (BUSY),
    .TICK_TGL (TICK_TGL)
  );

  always #5 CLK = ~CLK;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: LFSR values advanced one data step at a time.
  logic [15:0] m_data;
  logic [7:0]  m_ctrl;
  int          m_steps;

  // Feedback bit is 1 when an even number of tapped bits are set.
  function automatic logic [15:0] ref_lfsr16(input logic [15:0] v);
    int ones = 0;
    for (int i = 0; i < 16; i++) if (DTAPS[i] && v[i]) ones++;
    return (v << 1) | 16'((ones % 2) == 0);
  endfunction

  function automatic logic [7:0] ref_lfsr8(input logic [7:0] v);
    int ones = 0;
    for (int i = 0; i < 8; i++) if (CTAPS[i] && v[i]) ones++;
    return (v << 1) | 8'((ones % 2) == 0);
  endfunction

  function automatic logic [7:0] ref_mux(input logic [15:0] d, input logic [7:0] c);
    logic [7:0] r = '0;
    for (int j = 0; j < 8; j++) r[j] = c[j] ? d[2*j+1] : d[2*j];
    return r;
  endfunction

  task automatic model_step();
    m_data = ref_lfsr16(m_data);
    m_steps++;
    if ((m_steps % CSTEP) == 0) m_ctrl = ref_lfsr8(m_ctrl);
  endtask

  task automatic model_seed(input logic [15:0] d, input logic [7:0] c);
    m_data  = (d == 16'hFFFF) ? 16'h0000 : d;
    m_ctrl  = (c == 8'hFF) ? 8'h00 : c;
    m_steps = 0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clk1();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    for (int k = 1; k <= 20; k++) begin
      clk1();
      n = k;
      if (VALID) break;
    end
  endtask

  typedef struct {
    logic        en;
    logic        mode;
    logic        req;
    logic        exp_valid;
    logic [7:0]  exp_out;
    logic        exp_tgl;
    logic [15:0] exp_data;
    logic [7:0]  exp_ctrl;
  } vec_t;

  vec_t vt[10];

  initial begin
    int         n;
    int         en_cnt;
    int         nvalid;
    bit         first;
    logic [7:0] out_prev;

    // Free-run from reset, TICK_DIV=4: steps at edges 4 and 8, VALID one edge later.
    vt[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 16'h0000, 8'h00};
    vt[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 16'h0000, 8'h00};
    vt[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 16'h0000, 8'h00};
    vt[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 16'h0001, 8'h01};
    vt[4] = '{1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 1'b1, 16'h0001, 8'h01};
    vt[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 16'h0001, 8'h01};
    vt[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 16'h0001, 8'h01};
    vt[7] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 16'h0003, 8'h03};
    vt[8] = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h01, 1'b0, 16'h0003, 8'h03};
    vt[9] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h01, 1'b0, 16'h0003, 8'h03};

    RST = 1'b1; EN = 1'b1; MODE = 1'b0; REQ = 1'b0; SEED_LD = 1'b0;
    SEED_DATA = '0; SEED_CTRL = '0;
    clk1();
    clk1();
    RST = 1'b0;
    chk("reset OUT", OUT, 8'h00);
    chk("reset VALID", VALID, 1'b0);
    chk("reset BUSY", BUSY, 1'b0);
    chk("reset TICK_TGL", TICK_TGL, 1'b0);
    chk("reset data", dut.data_q, 16'h0000);
    chk("reset ctrl", dut.ctrl_q, 8'h00);

    for (int i = 0; i < 10; i++) begin
      EN = vt[i].en; MODE = vt[i].mode; REQ = vt[i].req;
      clk1();
      chk($sformatf("fr%0d VALID", i), VALID, vt[i].exp_valid);
      chk($sformatf("fr%0d OUT", i), OUT, vt[i].exp_out);
      chk($sformatf("fr%0d TICK_TGL", i), TICK_TGL, vt[i].exp_tgl);
      chk($sformatf("fr%0d data", i), dut.data_q, vt[i].exp_data);
      chk($sformatf("fr%0d ctrl", i), dut.ctrl_q, vt[i].exp_ctrl);
      chk($sformatf("fr%0d BUSY", i), BUSY, 1'b0);
    end

    // On-demand from reset, ROUNDS=2, with REQ held during BUSY.
    RST = 1'b1; REQ = 1'b0;
    clk1();
    RST = 1'b0;
    model_seed(16'h0000, 8'h00);
    MODE = 1'b1; REQ = 1'b1;
    clk1();
    chk("od accept BUSY", BUSY, 1'b1);
    chk("od accept VALID", VALID, 1'b0);
    clk1();
    chk("od gen1 BUSY", BUSY, 1'b1);
    clk1();
    model_step(); model_step();
    chk("od gen2 BUSY", BUSY, 1'b0);
    chk("od gen2 VALID", VALID, 1'b0);
    REQ = 1'b0;
    clk1();
    chk("od done VALID", VALID, 1'b1);
    chk("od done OUT", OUT, 8'h01);
    chk("od done data", dut.data_q, m_data);
    nvalid = 0;
    for (int k = 0; k < 6; k++) begin
      clk1();
      if (VALID) nvalid++;
    end
    chk("od no second VALID", nvalid, 0);

    // EN freeze mid-GEN.
    REQ = 1'b1;
    clk1();
    REQ = 1'b0;
    clk1();
    model_step();
    chk("frz gen BUSY", BUSY, 1'b1);
    chk("frz gen data", dut.data_q, m_data);
    EN = 1'b0;
    for (int k = 0; k < 10; k++) begin
      clk1();
      chk($sformatf("frz%0d BUSY", k), BUSY, 1'b1);
      chk($sformatf("frz%0d VALID", k), VALID, 1'b0);
      chk($sformatf("frz%0d data", k), dut.data_q, m_data);
      chk($sformatf("frz%0d ctrl", k), dut.ctrl_q, m_ctrl);
    end
    EN = 1'b1;
    clk1();
    model_step();
    chk("frz resume BUSY", BUSY, 1'b0);
    clk1();
    chk("frz resume VALID", VALID, 1'b1);
    chk("frz resume OUT", OUT, ref_mux(m_data, m_ctrl));
    chk("frz resume data", dut.data_q, m_data);

    // All-ones seed guard, then the post-reset free-run sequence again.
    out_prev = OUT;
    SEED_LD = 1'b1; SEED_DATA = 16'hFFFF; SEED_CTRL = 8'hFF; MODE = 1'b0;
    clk1();
    model_seed(SEED_DATA, SEED_CTRL);
    SEED_LD = 1'b0;
    chk("guard data", dut.data_q, 16'h0000);
    chk("guard ctrl", dut.ctrl_q, 8'h00);
    chk("guard OUT hold", OUT, out_prev);
    chk("guard VALID", VALID, 1'b0);
    wait_valid(n);
    model_step();
    chk("guard first latency", n, TDIV + 1);
    chk("guard first OUT", OUT, 8'h00);
    wait_valid(n);
    model_step();
    chk("guard second interval", n, TDIV);
    chk("guard second OUT", OUT, 8'h01);
    chk("guard second data", dut.data_q, m_data);

    // Seed load during GEN with a simultaneous REQ.
    MODE = 1'b1; REQ = 1'b1;
    clk1();
    chk("abort start BUSY", BUSY, 1'b1);
    out_prev = OUT;
    SEED_LD = 1'b1; SEED_DATA = 16'h1234; SEED_CTRL = 8'h56;
    clk1();
    model_seed(SEED_DATA, SEED_CTRL);
    SEED_LD = 1'b0; REQ = 1'b0;
    chk("abort BUSY", BUSY, 1'b0);
    chk("abort VALID", VALID, 1'b0);
    chk("abort OUT hold", OUT, out_prev);
    chk("abort data", dut.data_q, 16'h1234);
    chk("abort ctrl", dut.ctrl_q, 8'h56);
    nvalid = 0;
    for (int k = 0; k < 5; k++) begin
      clk1();
      if (VALID || BUSY) nvalid++;
    end
    chk("abort quiet", nvalid, 0);

    // Randomized free-run with EN gaps: one step per VALID, TICK_DIV enabled edges apart.
    SEED_LD = 1'b1; SEED_DATA = 16'($urandom); SEED_CTRL = 8'($urandom); MODE = 1'b0; EN = 1'b1;
    clk1();
    model_seed(SEED_DATA, SEED_CTRL);
    SEED_LD = 1'b0;
    first = 1'b1; en_cnt = 0; nvalid = 0;
    for (int c = 0; c < 4000; c++) begin
      EN  = ($urandom_range(0, 3) != 0);
      REQ = 1'($urandom);
      clk1();
      if (EN) en_cnt++;
      if (VALID) begin
        model_step();
        nvalid++;
        chk("rfr OUT", OUT, ref_mux(m_data, m_ctrl));
        chk("rfr data", dut.data_q, m_data);
        chk("rfr ctrl", dut.ctrl_q, m_ctrl);
        if (!first) chk("rfr interval", en_cnt, TDIV);
        first = 1'b0;
        en_cnt = 0;
      end
    end
    chk("rfr saw VALIDs", nvalid > 100, 1'b1);

    // Randomized on-demand: ROUNDS steps per VALID, BUSY never overlaps VALID.
    SEED_LD = 1'b1; SEED_DATA = 16'($urandom); SEED_CTRL = 8'($urandom); MODE = 1'b1; EN = 1'b1;
    clk1();
    model_seed(SEED_DATA, SEED_CTRL);
    SEED_LD = 1'b0;
    nvalid = 0;
    for (int c = 0; c < 3000; c++) begin
      EN  = ($urandom_range(0, 3) != 0);
      REQ = 1'($urandom);
      clk1();
      if (VALID) begin
        for (int r = 0; r < RND; r++) model_step();
        nvalid++;
        chk("rod OUT", OUT, ref_mux(m_data, m_ctrl));
        chk("rod data", dut.data_q, m_data);
        chk("rod ctrl", dut.ctrl_q, m_ctrl);
        chk("rod BUSY", BUSY, 1'b0);
      end
    end
    chk("rod saw VALIDs", nvalid > 100, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
